wb_write_arbiter: RTL
=====================

# wb_write_arbiter

Shares the register file's single write port between the pipeline writeback stage (the MEM/WB outputs after the MemToReg/Jal mux) and the long-latency multiply/divide unit. Pipeline writes always win. Multiply/divide results are queued in a small FIFO and drained in idle writeback cycles. A wait counter raises a stall request so the pipeline inserts a bubble when a queued result starves. The block sits between the MEM/WB register, the mul/div unit and the register file.

## Interface
- DEPTH, 2: mul/div result FIFO entries; power of two, ≥2.
- MAX_WAIT, 4: cycles the head entry may wait before StallReq is raised; ≥1.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WB_RegWrite  in  1  pipeline writeback valid.
- WB_Addr  in  5  pipeline destination register.
- WB_Data  in  32  pipeline write data.
- MD_Valid  in  1  mul/div result offered.
- MD_Addr  in  5  mul/div destination register.
- MD_Data  in  32  mul/div result.
- MD_Ready  out  1  FIFO can accept; registered, equals count < DEPTH.
- RF_WriteEn  out  1  register file write enable.
- RF_WriteAddr  out  5  register file write address.
- RF_WriteData  out  32  register file write data.
- StallReq  out  1  registered request for the pipeline to bubble MEM/WB.
- Pending  out  1  FIFO non-empty.

## Operation
- MD transfer occurs when MD_Valid and MD_Ready are both 1 at a rising edge. The entry {addr, data} is pushed at the FIFO tail. There is no bypass: every MD result passes through the FIFO.
- RF outputs are combinational from the current state and inputs.
- Rule 1: if WB_RegWrite=1, the RF outputs carry WB_*.
- Rule 2: otherwise, if the FIFO is non-empty, the RF outputs carry the head entry, which pops at the edge.
- Rule 3: otherwise, RF_WriteEn=0 and addr/data are 0.
- Writes to register 0 are squashed from the pipeline side: WB_RegWrite with WB_Addr=0 gives RF_WriteEn=0. It still counts as a pipeline cycle, so the FIFO does not drain that cycle.
- MD results addressed to register 0 are discarded at push and never enqueued. MD_Ready still handshakes them.
- Simultaneous push and pop are allowed. count is unchanged, the pointers advance, and the FIFO stays in order.
- MD_Ready is computed from the registered count only. When the FIFO is full it stays 0, even if a pop happens in that cycle.
- WAW ordering between the two sources is guaranteed upstream by the issue scoreboard. The arbiter never reorders or compares addresses.
- Wait counter: increments each cycle the FIFO is non-empty and the head does not pop; saturates at MAX_WAIT; clears to 0 on every pop and whenever the FIFO is empty.
- StallReq: set at the edge where the wait counter reaches MAX_WAIT; cleared at the edge after the head pops.
- The pipeline contract is that StallReq=1 yields WB_RegWrite=0 in the next cycle. If WB_RegWrite is still 1 anyway, the pipeline still wins and StallReq holds.

## Timing
- Reset values (asynchronous, Reset=0): FIFO pointers, count, wait counter and StallReq are 0. Outputs are MD_Ready=1, Pending=0, RF_WriteEn=0, RF_WriteAddr=0, RF_WriteData=0.
- FIFO storage is not reset.
- Reset asserted mid-operation drops all queued results. The mul/div unit is reset by the same signal.
- Latency from MD acceptance to RF write: minimum 1 cycle (the cycle after acceptance, if WB is idle).
- A pipeline write has 0 latency (combinational pass-through).
- StallReq rises exactly MAX_WAIT cycles after the head becomes eligible and is blocked every cycle.
- Under the pipeline contract, the head drains 1 cycle after StallReq rises, and StallReq falls the cycle after that.
- Pointer width is log2(DEPTH) and wraps modulo DEPTH. count is log2(DEPTH)+1 bits.

## Structure
- Shared package: REG_ADDR_W=5, DATA_W=32, and the zero-register constant.
- One sub-module: wb_result_fifo, a synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- Arbitration, the wait counter and StallReq stay in the top level.

## Test plan
- Reset sequence: assert Reset=0 mid-transfer with 2 entries queued → all outputs at reset values immediately; after release, Pending=0 and MD_Ready=1.
- Idle WB: MD pushes {addr 5, 0x1234} at cycle N → RF_WriteEn=1, addr 5, data 0x1234 at cycle N+1; Pending=0 at N+2.
- Conflict: WB writes {7, 0xAAAA} continuously while MD pushes {9, 0xBBBB} then {10, 0xCCCC} → RF shows only WB; MD_Ready=0 after the 2nd push; the 3rd MD_Valid is held off.
- Starvation: FIFO holds 1 entry and WB is busy with MAX_WAIT=4 → StallReq=1 after 4 cycles; WB idles the next cycle → head written; StallReq=0 the cycle after.
- Zero register: WB_Addr=0 with WB_RegWrite=1 → RF_WriteEn=0 and the FIFO head does not pop; MD result to addr 0 → accepted, never written, Pending stays 0.
- Full push/pop: FIFO full, WB idle, MD_Valid=1 → pop occurs, no push that cycle (MD_Ready=0); push accepted the next cycle; order of writes preserved.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, the zero-register constant and the queued mul/div result type
// for the register-file write-port arbiter.
package wb_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO holding mul/div results until the write port is free.
// Pointers and count reset; storage does not.
module wb_result_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              wdata,
    output wb_entry_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, mul/div
// results queue and drain in idle writeback cycles, starvation raises StallReq.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_Addr,
    input  logic [DATA_W-1:0]     WB_Data,
    input  logic                  MD_Valid,
    input  logic [REG_ADDR_W-1:0] MD_Addr,
    input  logic [DATA_W-1:0]     MD_Data,
    output logic                  MD_Ready,
    output logic                  RF_WriteEn,
    output logic [REG_ADDR_W-1:0] RF_WriteAddr,
    output logic [DATA_W-1:0]     RF_WriteData,
    output logic                  StallReq,
    output logic                  Pending
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    // Register-0 results still handshake but are dropped before the FIFO.
    assign push       = MD_Valid && MD_Ready && (MD_Addr != ZERO_REG);
    assign pop        = !WB_RegWrite && !empty;
    assign push_entry = '{addr: MD_Addr, data: MD_Data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Ready depends only on the registered count, so a full FIFO refuses
    // even in a cycle where it pops.
    assign MD_Ready = (count < CNT_W'(DEPTH));
    assign Pending  = !empty;

    always_comb begin
        RF_WriteEn   = 1'b0;
        RF_WriteAddr = '0;
        RF_WriteData = '0;
        if (WB_RegWrite) begin
            RF_WriteEn   = (WB_Addr != ZERO_REG);
            RF_WriteAddr = WB_Addr;
            RF_WriteData = WB_Data;
        end else if (pop) begin
            RF_WriteEn   = 1'b1;
            RF_WriteAddr = head.addr;
            RF_WriteData = head.data;
        end
    end

    always_comb begin
        wait_next = wait_cnt;
        if (empty || pop) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    // StallReq holds while the head stays blocked and drops with its pop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
            StallReq <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            if (empty || pop) begin
                StallReq <= 1'b0;
            end else if (wait_next == WAIT_MAX) begin
                StallReq <= 1'b1;
            end
        end
    end

endmodule
